// File: rtl/intersection_time_base.sv
// 12-hour time-of-day source for the intersection simulator, with rush-hour decode,
// second/hour strobes and a valid/ready preset port serviced by a two-state load FSM.
module intersection_time_base #(
    parameter int TICKS_PER_SEC = 1,
    parameter int INIT_HOUR     = 6,
    parameter bit INIT_AM_PM    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_valid,
    input  logic [3:0] set_hour,
    input  logic [5:0] set_minute,
    input  logic [5:0] set_second,
    input  logic       set_am_pm,
    output logic       set_ready,
    output logic       set_err,
    output logic [3:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       am_pm,
    output logic       rush_hour,
    output logic       sec_tick,
    output logic       hour_tick
);

    localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_hour;
    logic [5:0]    r_minute;
    logic [5:0]    r_second;
    logic          r_am_pm;
    logic          r_set_ready;
    logic          r_set_err;
    logic          r_sec_tick;
    logic          r_hour_tick;

    logic [3:0]    w_hour_n;
    logic [5:0]    w_minute_n;
    logic [5:0]    w_second_n;
    logic          w_am_pm_n;
    logic          w_hour_carry;
    logic          w_wrap;
    logic          w_load_legal;

    function automatic logic fields_legal(input logic [3:0] h,
                                          input logic [5:0] m,
                                          input logic [5:0] s);
        return (h >= 4'd1) && (h <= 4'd12) && (m <= 6'd59) && (s <= 6'd59);
    endfunction

    function automatic logic is_rush(input logic [3:0] h, input logic pm);
        return (!pm && (h == 4'd7 || h == 4'd8)) || (pm && (h == 4'd5 || h == 4'd6));
    endfunction

    assign w_wrap       = en && (r_presc == PRESC_LAST);
    assign w_load_legal = fields_legal(set_hour, set_minute, set_second);
    assign w_hour_carry = (r_minute == 6'd59) && (r_second == 6'd59);

    // Time one second later; am_pm flips only on the 11 -> 12 hour step.
    always_comb begin
        w_second_n = r_second;
        w_minute_n = r_minute;
        w_hour_n   = r_hour;
        w_am_pm_n  = r_am_pm;
        if (r_second == 6'd59) begin
            w_second_n = 6'd0;
            if (r_minute == 6'd59) begin
                w_minute_n = 6'd0;
                if (r_hour == 4'd11) begin
                    w_hour_n  = 4'd12;
                    w_am_pm_n = ~r_am_pm;
                end else if (r_hour == 4'd12) begin
                    w_hour_n = 4'd1;
                end else begin
                    w_hour_n = r_hour + 4'd1;
                end
            end else begin
                w_minute_n = r_minute + 6'd1;
            end
        end else begin
            w_second_n = r_second + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_hour      <= 4'(INIT_HOUR);
            r_minute    <= 6'd0;
            r_second    <= 6'd0;
            r_am_pm     <= INIT_AM_PM;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
        end else begin
            r_set_err   <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A load always pre-empts an advance on the same edge.
                    if (set_valid) begin
                        r_state     <= S_HOLD;
                        r_set_ready <= 1'b0;
                        if (w_load_legal) begin
                            r_hour   <= set_hour;
                            r_minute <= set_minute;
                            r_second <= set_second;
                            r_am_pm  <= set_am_pm;
                            r_presc  <= '0;
                        end else begin
                            r_set_err <= 1'b1;
                        end
                    end else if (en) begin
                        if (w_wrap) begin
                            r_presc     <= '0;
                            r_hour      <= w_hour_n;
                            r_minute    <= w_minute_n;
                            r_second    <= w_second_n;
                            r_am_pm     <= w_am_pm_n;
                            r_sec_tick  <= 1'b1;
                            r_hour_tick <= w_hour_carry;
                        end else begin
                            r_presc <= r_presc + PRESC_ONE;
                        end
                    end
                end
                S_HOLD: begin
                    r_state     <= S_IDLE;
                    r_set_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_set_ready <= 1'b1;
                end
            endcase
        end
    end

    assign set_ready = r_set_ready;
    assign set_err   = r_set_err;
    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign am_pm     = r_am_pm;
    assign rush_hour = is_rush(r_hour, r_am_pm);
    assign sec_tick  = r_sec_tick;
    assign hour_tick = r_hour_tick;

endmodule

// File: tb/tb_intersection_time_base.sv
// Bench for intersection_time_base: two instances (1 and 4 ticks/second) share stimulus and are
// checked every cycle against a seconds-of-day reference model, plus table vectors and corner sequences.
module tb_intersection_time_base;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       sv  = 1'b0;
    logic [3:0] sh  = 4'd1;
    logic [5:0] sm  = 6'd0;
    logic [5:0] ss  = 6'd0;
    logic       sap = 1'b0;

    logic       rdy1, err1, ap1, rh1, st1, ht1;
    logic [3:0] hr1;
    logic [5:0] mn1, sc1;
    logic       rdy4, err4, ap4, rh4, st4, ht4;
    logic [3:0] hr4;
    logic [5:0] mn4, sc4;

    always #5 clk = ~clk;

    intersection_time_base #(.TICKS_PER_SEC(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .set_valid(sv), .set_hour(sh), .set_minute(sm),
        .set_second(ss), .set_am_pm(sap), .set_ready(rdy1), .set_err(err1), .hour(hr1),
        .minute(mn1), .second(sc1), .am_pm(ap1), .rush_hour(rh1), .sec_tick(st1), .hour_tick(ht1));

    intersection_time_base #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .set_valid(sv), .set_hour(sh), .set_minute(sm),
        .set_second(ss), .set_am_pm(sap), .set_ready(rdy4), .set_err(err4), .hour(hr4),
        .minute(mn4), .second(sc4), .am_pm(ap4), .rush_hour(rh4), .sec_tick(st4), .hour_tick(ht4));

    logic [21:0] a1, a4;
    assign a1 = {rdy1, err1, hr1, mn1, sc1, ap1, rh1, st1, ht1};
    assign a4 = {rdy4, err4, hr4, mn4, sc4, ap4, rh4, st4, ht4};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    string phase = "reset";

    // Reference model: time kept as seconds since midnight (0..86399).
    int tps [2] = '{1, 4};
    int m_tod[2];
    int m_pre[2];
    bit m_hold[2], m_err[2], m_st[2], m_ht[2];

    function automatic int to_tod(int h, int m, int s, bit pm);
        return (((h == 12) ? 0 : h) + (pm ? 12 : 0)) * 3600 + m * 60 + s;
    endfunction

    function automatic logic [21:0] exp_pack(int k);
        int h24, h12, mi, se;
        bit pm, rush;
        h24  = m_tod[k] / 3600;
        mi   = (m_tod[k] / 60) % 60;
        se   = m_tod[k] % 60;
        h12  = (h24 % 12 == 0) ? 12 : h24 % 12;
        pm   = (h24 >= 12);
        rush = (h24 == 7 || h24 == 8 || h24 == 17 || h24 == 18);
        return {~m_hold[k], m_err[k], 4'(h12), 6'(mi), 6'(se), pm, rush, m_st[k], m_ht[k]};
    endfunction

    function automatic void model_step(int k);
        m_err[k] = 1'b0;
        m_st[k]  = 1'b0;
        m_ht[k]  = 1'b0;
        if (rst) begin
            m_tod[k]  = 6 * 3600;
            m_pre[k]  = 0;
            m_hold[k] = 1'b0;
        end else if (m_hold[k]) begin
            m_hold[k] = 1'b0;
        end else if (sv) begin
            m_hold[k] = 1'b1;
            if (sh >= 1 && sh <= 12 && sm <= 59 && ss <= 59) begin
                m_tod[k] = to_tod(int'(sh), int'(sm), int'(ss), sap);
                m_pre[k] = 0;
            end else begin
                m_err[k] = 1'b1;
            end
        end else if (en) begin
            if (m_pre[k] == tps[k] - 1) begin
                m_pre[k] = 0;
                m_tod[k] = (m_tod[k] + 1) % 86400;
                m_st[k]  = 1'b1;
                m_ht[k]  = (m_tod[k] % 3600 == 0);
            end else begin
                m_pre[k]++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s/%s cyc %0d: got %h want %h", phase, name, cyc, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
        chk("model1", 32'(a1), 32'(exp_pack(0)));
        chk("model4", 32'(a4), 32'(exp_pack(1)));
    endtask

    task automatic load(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s, input logic pm);
        sv = 1'b1; sh = h; sm = m; ss = s; sap = pm;
        cycle();
        sv = 1'b0;
    endtask

    typedef struct {
        logic [3:0] h;  logic [5:0] m;  logic [5:0] s;  logic ap;
        logic [3:0] eh; logic [5:0] em; logic [5:0] es; logic eap; logic erush; logic eht;
    } vec_t;
    vec_t tab[8];

    logic [16:0] snap1, snap4;
    logic [3:0]  bad_h [4];
    logic [5:0]  bad_m [4];
    logic [5:0]  bad_s [4];
    int          guard;

    initial begin
        tab[0] = '{4'd8,  6'd59, 6'd59, 1'b0, 4'd9,  6'd0,  6'd0,  1'b0, 1'b0, 1'b1};
        tab[1] = '{4'd11, 6'd59, 6'd59, 1'b0, 4'd12, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1};
        tab[2] = '{4'd12, 6'd59, 6'd59, 1'b1, 4'd1,  6'd0,  6'd0,  1'b1, 1'b0, 1'b1};
        tab[3] = '{4'd11, 6'd59, 6'd59, 1'b1, 4'd12, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1};
        tab[4] = '{4'd4,  6'd59, 6'd59, 1'b1, 4'd5,  6'd0,  6'd0,  1'b1, 1'b1, 1'b1};
        tab[5] = '{4'd6,  6'd59, 6'd59, 1'b1, 4'd7,  6'd0,  6'd0,  1'b1, 1'b0, 1'b1};
        tab[6] = '{4'd7,  6'd30, 6'd15, 1'b0, 4'd7,  6'd30, 6'd16, 1'b0, 1'b1, 1'b0};
        tab[7] = '{4'd12, 6'd0,  6'd59, 1'b0, 4'd12, 6'd1,  6'd0,  1'b0, 1'b0, 1'b0};
        bad_h = '{4'd13, 4'd0, 4'd5, 4'd5};
        bad_m = '{6'd10, 6'd10, 6'd60, 6'd0};
        bad_s = '{6'd10, 6'd10, 6'd0, 6'd63};

        // Reset state
        rst = 1'b1; en = 1'b1; sv = 1'b0;
        cycle();
        cycle();
        chk("reset1", 32'(a1), 32'({1'b1, 1'b0, 4'd6, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("reset4", 32'(a4), 32'({1'b1, 1'b0, 4'd6, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}));

        // One hour of seconds reaches the morning rush
        phase = "hour"; rst = 1'b0;
        repeat (3600) cycle();
        chk("7am", 32'({hr1, mn1, sc1, ap1, rh1, ht1}), 32'({4'd7, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1}));

        // Table: load, HOLD edge, one advance edge
        phase = "table";
        for (int i = 0; i < 8; i++) begin
            load(tab[i].h, tab[i].m, tab[i].s, tab[i].ap);
            chk("tab_noTick", 32'({rdy1, st1}), 32'(2'b00));
            cycle();
            cycle();
            chk($sformatf("tab%0d", i), 32'({hr1, mn1, sc1, ap1, rh1, ht1, st1}),
                32'({tab[i].eh, tab[i].em, tab[i].es, tab[i].eap, tab[i].erush, tab[i].eht, 1'b1}));
        end

        // Illegal loads: error pulse, one busy cycle, time frozen through both edges
        phase = "illegal";
        for (int i = 0; i < 4; i++) begin
            snap1 = {hr1, mn1, sc1, ap1};
            load(bad_h[i], bad_m[i], bad_s[i], 1'b1);
            chk("err_hold", 32'({rdy1, err1, hr1, mn1, sc1, ap1}), 32'({1'b0, 1'b1, snap1}));
            cycle();
            chk("err_done", 32'({rdy1, err1, hr1, mn1, sc1, ap1}), 32'({1'b1, 1'b0, snap1}));
        end

        // Legal load on the very edge dut4's prescaler would wrap
        phase = "wrapload";
        guard = 0;
        while (m_pre[1] != 3 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("wrap_found", 32'(guard < 10), 32'(1));
        load(4'd3, 6'd20, 6'd40, 1'b1);
        chk("wrap_load4", 32'({hr4, mn4, sc4, ap4, st4, ht4}), 32'({4'd3, 6'd20, 6'd40, 1'b1, 1'b0, 1'b0}));
        cycle();
        repeat (4) cycle();
        chk("tps4_adv", 32'({hr4, mn4, sc4, st4}), 32'({4'd3, 6'd20, 6'd41, 1'b1}));

        // en=0 freezes both instances; strobes stay low
        phase = "freeze";
        snap1 = {hr1, mn1, sc1, ap1};
        snap4 = {hr4, mn4, sc4, ap4};
        en = 1'b0;
        repeat (10) cycle();
        chk("frz1", 32'({hr1, mn1, sc1, ap1, st1}), 32'({snap1, 1'b0}));
        chk("frz4", 32'({hr4, mn4, sc4, ap4, st4}), 32'({snap4, 1'b0}));
        load(4'd10, 6'd5, 6'd6, 1'b0);
        chk("frz_load", 32'({hr1, mn1, sc1, ap1}), 32'({4'd10, 6'd5, 6'd6, 1'b0}));
        cycle();
        en = 1'b1;

        // Reset while in HOLD, after legal and illegal loads
        phase = "rst_hold";
        load(4'd2, 6'd2, 6'd2, 1'b1);
        rst = 1'b1;
        cycle();
        chk("rst_legal", 32'(a1), 32'({1'b1, 1'b0, 4'd6, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        load(4'd15, 6'd2, 6'd2, 1'b1);
        chk("err_seen", 32'(err1), 32'(1));
        rst = 1'b1;
        cycle();
        chk("rst_illegal", 32'({rdy1, err1, rdy4, err4}), 32'(4'b1010));
        rst = 1'b0;

        // Randomized traffic against the model
        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 3) != 0);
            sv  = ($urandom_range(0, 5) == 0);
            sh  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 12)) : 4'($urandom_range(0, 15));
            sm  = ($urandom_range(0, 1) != 0) ? 6'd59 : 6'($urandom_range(0, 63));
            ss  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(56, 59)) : 6'($urandom_range(0, 63));
            sap = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b0; sv = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
